// File: rtl/mmu_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_arbiter
//
// Arbitrates the instruction-side and data-side requesters onto the single
// MMU virtual port. One transaction is in flight at a time. The grant is held
// until the MMU acks, the requester withdraws, or the grant timeout expires.
//
// Parameters:
//   TIMEOUT      grant cycles without m_ack_i before the transaction is
//                aborted with an error ack; 0 disables the timeout.
//
// Optional feature (compile-time macro):
//   ARB_ROUND_ROBIN_EN  defined: contention goes to the side not last served
//                       (instruction side wins the first contention after
//                       reset). Undefined: the data side always wins
//                       contention.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_addr_i/i_data_i/i_rd_i/i_we_i instruction-side request (held until ack)
//   i_data_o/i_ack_o/i_pfault_o/i_err_o  instruction-side response
//   d_addr_i/d_data_i/d_rd_i/d_we_i data-side request (held until ack)
//   d_data_o/d_ack_o/d_pfault_o/d_err_o  data-side response
//   m_addr_o/m_data_o/m_rd_o/m_we_o shared MMU request
//   m_data_i/m_ack_i/m_pfault_i     MMU read data, ack, page-fault flag
//   gnt_o                           one-hot grant: bit0 instr, bit1 data
// -----------------------------------------------------------------------------
module mmu_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [31:0]  i_addr_i,
    input  logic [255:0] i_data_i,
    input  logic         i_rd_i,
    input  logic         i_we_i,
    output logic [255:0] i_data_o,
    output logic         i_ack_o,
    output logic         i_pfault_o,
    output logic         i_err_o,

    input  logic [31:0]  d_addr_i,
    input  logic [255:0] d_data_i,
    input  logic         d_rd_i,
    input  logic         d_we_i,
    output logic [255:0] d_data_o,
    output logic         d_ack_o,
    output logic         d_pfault_o,
    output logic         d_err_o,

    output logic [31:0]  m_addr_o,
    output logic [255:0] m_data_o,
    output logic         m_rd_o,
    output logic         m_we_o,
    input  logic [255:0] m_data_i,
    input  logic         m_ack_i,
    input  logic         m_pfault_i,

    output logic [1:0]   gnt_o
);

    // State encoding doubles as the one-hot grant status.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;

    logic [1:0] state_q, state_d;
    logic [7:0] tmo_cnt_q;
    logic       arm_q;
    logic       i_pend, d_pend, x_pend;
    logic       pick_i;
    logic       tmo_hit;

    assign i_pend = i_rd_i | i_we_i;
    assign d_pend = d_rd_i | d_we_i;
    assign x_pend = (state_q == GNT_I) ? i_pend :
                    (state_q == GNT_D) ? d_pend : 1'b0;

    // An ack arriving in the same cycle as the limit suppresses the abort.
    assign tmo_hit = (TIMEOUT != 0) && x_pend && !m_ack_i &&
                     (32'(tmo_cnt_q) == TIMEOUT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_i_q;  // 1: instruction side was served last

    assign pick_i = i_pend & (~d_pend | ~last_i_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_i_q <= 1'b0;
        end else if (x_pend && m_ack_i) begin
            last_i_q <= (state_q == GNT_I);
        end
    end
`else
    assign pick_i = i_pend & ~d_pend;
`endif

    // Next-state logic. arm_q holds off arbitration for the first edge after
    // reset release so a grant can appear no earlier than the second edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arm_q) begin
                    if (pick_i)      state_d = GNT_I;
                    else if (d_pend) state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (!x_pend || m_ack_i || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmo_cnt_q <= 8'd0;
            arm_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            // Held at zero in IDLE, so every grant starts counting from zero.
            if (state_q == IDLE) begin
                tmo_cnt_q <= 8'd0;
            end else if (!m_ack_i && tmo_cnt_q != 8'hFF) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    // Combinational request/response steering for the granted side.
    always_comb begin
        m_addr_o   = 32'd0;
        m_data_o   = 256'd0;
        m_rd_o     = 1'b0;
        m_we_o     = 1'b0;
        i_ack_o    = 1'b0;
        i_pfault_o = 1'b0;
        i_err_o    = 1'b0;
        d_ack_o    = 1'b0;
        d_pfault_o = 1'b0;
        d_err_o    = 1'b0;
        case (state_q)
            GNT_I: begin
                m_addr_o   = i_addr_i;
                m_data_o   = i_data_i;
                m_rd_o     = i_rd_i & ~tmo_hit;
                m_we_o     = i_we_i & ~tmo_hit;
                i_ack_o    = i_pend & (m_ack_i | tmo_hit);
                i_pfault_o = i_pend & m_pfault_i;
                i_err_o    = tmo_hit;
            end
            GNT_D: begin
                m_addr_o   = d_addr_i;
                m_data_o   = d_data_i;
                m_rd_o     = d_rd_i & ~tmo_hit;
                m_we_o     = d_we_i & ~tmo_hit;
                d_ack_o    = d_pend & (m_ack_i | tmo_hit);
                d_pfault_o = d_pend & m_pfault_i;
                d_err_o    = tmo_hit;
            end
            default: ;
        endcase
    end

    assign i_data_o = m_data_i;
    assign d_data_o = m_data_i;
    assign gnt_o    = state_q;

endmodule

// File: tb/tb_mmu_arbiter.sv
`timescale 1ns/1ps
module tb_mmu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [31:0]  i_addr_i = '0, d_addr_i = '0;
    logic [255:0] i_data_i = '0, d_data_i = '0, m_data_i = '0;
    logic         i_rd_i = 0, i_we_i = 0, d_rd_i = 0, d_we_i = 0;
    logic         m_ack_i = 0, m_pfault_i = 0;

    logic [255:0] i_data_o, d_data_o, m_data_o;
    logic         i_ack_o, i_pfault_o, i_err_o;
    logic         d_ack_o, d_pfault_o, d_err_o;
    logic [31:0]  m_addr_o;
    logic         m_rd_o, m_we_o;
    logic [1:0]   gnt_o;

    // Second instance with the timeout disabled, sharing all inputs.
    logic [255:0] nt_i_data_o, nt_d_data_o, nt_m_data_o;
    logic         nt_i_ack_o, nt_i_pfault_o, nt_i_err_o;
    logic         nt_d_ack_o, nt_d_pfault_o, nt_d_err_o;
    logic [31:0]  nt_m_addr_o;
    logic         nt_m_rd_o, nt_m_we_o;
    logic [1:0]   nt_gnt_o;

    mmu_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_rd_i(i_rd_i), .i_we_i(i_we_i),
        .i_data_o(i_data_o), .i_ack_o(i_ack_o), .i_pfault_o(i_pfault_o), .i_err_o(i_err_o),
        .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i),
        .d_data_o(d_data_o), .d_ack_o(d_ack_o), .d_pfault_o(d_pfault_o), .d_err_o(d_err_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_rd_o(m_rd_o), .m_we_o(m_we_o),
        .m_data_i(m_data_i), .m_ack_i(m_ack_i), .m_pfault_i(m_pfault_i),
        .gnt_o(gnt_o)
    );

    mmu_arbiter #(.TIMEOUT(0)) dut_nt (
        .clk(clk), .rst_n(rst_n),
        .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_rd_i(i_rd_i), .i_we_i(i_we_i),
        .i_data_o(nt_i_data_o), .i_ack_o(nt_i_ack_o), .i_pfault_o(nt_i_pfault_o), .i_err_o(nt_i_err_o),
        .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i),
        .d_data_o(nt_d_data_o), .d_ack_o(nt_d_ack_o), .d_pfault_o(nt_d_pfault_o), .d_err_o(nt_d_err_o),
        .m_addr_o(nt_m_addr_o), .m_data_o(nt_m_data_o), .m_rd_o(nt_m_rd_o), .m_we_o(nt_m_we_o),
        .m_data_i(m_data_i), .m_ack_i(m_ack_i), .m_pfault_i(m_pfault_i),
        .gnt_o(nt_gnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected response: which side acks, error flag, page-fault flag.
    typedef struct packed {
        logic [1:0] side;
        logic       err;
        logic       pf;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t sb_pop();
        exp_t e;
        e = '{side: 2'b11, err: 1'b1, pf: 1'b1};  // impossible response if empty
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.side = {d_ack_o, i_ack_o};
        o.err  = i_err_o | d_err_o;
        o.pf   = i_pfault_o | d_pfault_o;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [255:0] pat;
        pat = {8{32'hC0DE_0001}};
        m_data_i = pat;
        i_rd_i = 1; d_we_i = 1; m_ack_i = 1;
        #3;
        n_checks++;
        if ({gnt_o, m_rd_o, m_we_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {gnt_o, m_rd_o, m_we_o});
        end
        e = observed();
        n_checks++;
        if (e !== 4'b0) begin
            n_fail++; $display("FAIL reset_resp: got %b expected 0000", e);
        end
        n_checks++;
        if (m_addr_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0", m_addr_o);
        end
        n_checks++;
        if (i_data_o !== pat || d_data_o !== pat) begin
            n_fail++; $display("FAIL reset_data: got %h expected %h", i_data_o, pat);
        end
        tick(); tick();
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_hold_gnt: got %b expected 00", gnt_o);
        end
        i_rd_i = 0; d_we_i = 0; m_ack_i = 0;
        rst_n = 1;
        tick(); tick();
    endtask

    task automatic test_contention();
        logic [1:0] first, second, cur;
        exp_t e, o;
        m_data_i = {8{$urandom}};
        tick();
        i_addr_i = 32'h0000_2000; i_rd_i = 1;
        d_addr_i = 32'h0000_3000; d_data_i = {8{32'h1234_5678}}; d_we_i = 1;
`ifdef ARB_ROUND_ROBIN_EN
        first = 2'b01; second = 2'b10;
`else
        first = 2'b10; second = 2'b01;
`endif
        sb.push_back('{side: first,  err: 1'b0, pf: 1'b0});
        sb.push_back('{side: second, err: 1'b0, pf: 1'b0});
        for (int k = 0; k < 2; k++) begin
            cur = (k == 0) ? first : second;
            tick();
            n_checks++;
            if (gnt_o !== cur) begin
                n_fail++; $display("FAIL cont_gnt%0d: got %b expected %b", k, gnt_o, cur);
            end
            n_checks++;
            if (m_addr_o !== ((cur == 2'b01) ? 32'h0000_2000 : 32'h0000_3000)) begin
                n_fail++; $display("FAIL cont_addr%0d: got %h", k, m_addr_o);
            end
            tick();
            m_ack_i = 1;
            #1;
            e = sb_pop(); o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL cont_resp%0d: got %b expected %b", k, o, e);
            end
            tick();
            m_ack_i = 0;
            if (cur == 2'b01) i_rd_i = 0; else d_we_i = 0;
            #1;
            n_checks++;
            if (gnt_o !== 2'b00) begin
                n_fail++; $display("FAIL cont_idle%0d: got %b expected 00", k, gnt_o);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        exp_t e, o;
        int w;
        i_rd_i = 1; d_rd_i = 1;
        for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            sb.push_back('{side: want, err: 1'b0, pf: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            w = 0;
            while (gnt_o == 2'b00 && w < 5) begin
                tick(); w++;
            end
            n_checks++;
            if (gnt_o !== want) begin
                n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt_o, want);
            end
            m_ack_i = 1;
            #1;
            e = sb_pop(); o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL rr_resp%0d: got %b expected %b", k, o, e);
            end
            tick();
            m_ack_i = 0;
        end
        i_rd_i = 0; d_rd_i = 0;
        tick();
    endtask

    task automatic test_single_read();
        exp_t e, o;
        logic [255:0] pat;
        pat = {8{32'hFACE_0000 ^ $urandom}};
        m_data_i = pat;
        tick();
        i_addr_i = 32'h0000_1040; i_rd_i = 1;
        sb.push_back('{side: 2'b01, err: 1'b0, pf: 1'b0});
        tick();
        n_checks++;
        if ({gnt_o, m_rd_o, m_we_o} !== 4'b0110) begin
            n_fail++; $display("FAIL rd_gnt: got %b expected 0110", {gnt_o, m_rd_o, m_we_o});
        end
        n_checks++;
        if (m_addr_o !== 32'h0000_1040) begin
            n_fail++; $display("FAIL rd_addr: got %h expected 00001040", m_addr_o);
        end
        tick();
        n_checks++;
        if (i_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_early_ack: got %b expected 0", i_ack_o);
        end
        tick();
        m_ack_i = 1;
        #1;
        e = sb_pop(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL rd_resp: got %b expected %b", o, e);
        end
        n_checks++;
        if (i_data_o !== pat) begin
            n_fail++; $display("FAIL rd_data: got %h expected %h", i_data_o, pat);
        end
        tick();
        m_ack_i = 0; i_rd_i = 0;
        #1;
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL rd_idle: got %b expected 00", gnt_o);
        end
    endtask

    task automatic test_pfault();
        exp_t e, o;
        tick();
        d_addr_i = 32'h0000_5000; d_rd_i = 1;
        sb.push_back('{side: 2'b10, err: 1'b0, pf: 1'b1});
        tick();
        n_checks++;
        if (gnt_o !== 2'b10) begin
            n_fail++; $display("FAIL pf_gnt: got %b expected 10", gnt_o);
        end
        m_ack_i = 1; m_pfault_i = 1;
        #1;
        e = sb_pop(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL pf_resp: got %b expected %b", o, e);
        end
        n_checks++;
        if (i_pfault_o !== 1'b0) begin
            n_fail++; $display("FAIL pf_iside: got %b expected 0", i_pfault_o);
        end
        tick();
        m_ack_i = 0; m_pfault_i = 0; d_rd_i = 0;
        #1;
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL pf_idle: got %b expected 00", gnt_o);
        end
    endtask

    task automatic test_timeout();
        exp_t e, o;
        tick();
        d_addr_i = 32'h0000_6000; d_rd_i = 1;
        sb.push_back('{side: 2'b10, err: 1'b1, pf: 1'b0});
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            if (c < 5) begin
                n_checks++;
                if ({gnt_o, d_ack_o, d_err_o, m_rd_o} !== 5'b10001) begin
                    n_fail++; $display("FAIL tmo_wait%0d: got %b expected 10001", c, {gnt_o, d_ack_o, d_err_o, m_rd_o});
                end
            end else begin
                e = sb_pop(); o = observed();
                n_checks++;
                if (o !== e) begin
                    n_fail++; $display("FAIL tmo_resp: got %b expected %b", o, e);
                end
                n_checks++;
                if (m_rd_o !== 1'b0) begin
                    n_fail++; $display("FAIL tmo_mrd: got %b expected 0", m_rd_o);
                end
            end
        end
        tick();
        d_rd_i = 0;
        #1;
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL tmo_idle: got %b expected 00", gnt_o);
        end
        tick(); tick();
    endtask

    task automatic test_timeout_disabled();
        int bad;
        bad = 0;
        tick();
        d_rd_i = 1;
        tick();
        for (int c = 0; c < 300; c++) begin
            n_checks++;
            if ({nt_gnt_o, nt_d_ack_o, nt_d_err_o} !== 4'b1000) begin
                n_fail++; bad++;
                if (bad < 4) $display("FAIL tmo0_cyc%0d: got %b expected 1000", c, {nt_gnt_o, nt_d_ack_o, nt_d_err_o});
            end
            tick();
        end
        d_rd_i = 0;
        tick(); tick();
        n_checks++;
        if (nt_gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL tmo0_idle: got %b expected 00", nt_gnt_o);
        end
    endtask

    task automatic test_reset_mid_grant();
        exp_t e, o;
        tick();
        i_addr_i = 32'h0000_7000; i_rd_i = 1;
        tick();
        n_checks++;
        if (gnt_o !== 2'b01) begin
            n_fail++; $display("FAIL rst_pre_gnt: got %b expected 01", gnt_o);
        end
        tick();
        rst_n = 0; m_ack_i = 1;
        #1;
        n_checks++;
        if ({gnt_o, m_rd_o, i_ack_o, i_err_o} !== 5'b0) begin
            n_fail++; $display("FAIL rst_abort: got %b expected 00000", {gnt_o, m_rd_o, i_ack_o, i_err_o});
        end
        tick();
        m_ack_i = 0; rst_n = 1;
        sb.push_back('{side: 2'b01, err: 1'b0, pf: 1'b0});
        tick();
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL rst_first_edge: got %b expected 00", gnt_o);
        end
        tick();
        n_checks++;
        if (gnt_o !== 2'b01) begin
            n_fail++; $display("FAIL rst_regrant: got %b expected 01", gnt_o);
        end
        m_ack_i = 1;
        #1;
        e = sb_pop(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL rst_resp: got %b expected %b", o, e);
        end
        tick();
        m_ack_i = 0; i_rd_i = 0;
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_contention();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_single_read();
        test_pfault();
        test_timeout();
        test_timeout_disabled();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

endmodule
